udp_tx_wrr_scheduler: RTL and testbench

Packet-level weighted round-robin scheduler that shares the single UDP TX header/payload path between `S_COUNT` requesters. It sits beside the UDP TX multiplexer. It watches the requesters' header-valid lines and the downstream header and payload handshakes, and drives a registered one-hot grant that selects which requester the mux forwards. An optional payload-stall watchdog releases a grant held by a stuck source.

---
 rtl/udp_tx_wrr_scheduler_if.sv | 36 +++
 rtl/udp_tx_wrr_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_udp_tx_wrr_scheduler.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/udp_tx_wrr_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : udp_tx_wrr_scheduler_if
// Brief    : Requester/downstream handshake and grant bundle of the UDP TX WRR scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface udp_tx_wrr_scheduler_if #(
    parameter int S_COUNT      = 2,
    parameter int WEIGHT_WIDTH = 4
);
    localparam int c_idx_w = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;

    logic [S_COUNT-1:0]              req;
    logic [S_COUNT*WEIGHT_WIDTH-1:0] weight;
    logic                            hdr_valid;
    logic                            hdr_ready;
    logic                            tvalid;
    logic                            tready;
    logic                            tlast;
    logic [S_COUNT-1:0]              grant;
    logic [c_idx_w-1:0]              grant_index;
    logic                            busy;
    logic                            timeout;

    // master = scheduler side, slave = requesters / mux side
    modport master (
        input  req, weight, hdr_valid, hdr_ready, tvalid, tready, tlast,
        output grant, grant_index, busy, timeout
    );

    modport slave (
        output req, weight, hdr_valid, hdr_ready, tvalid, tready, tlast,
        input  grant, grant_index, busy, timeout
    );
endinterface
`default_nettype wire

// File: rtl/udp_tx_wrr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : udp_tx_wrr_scheduler
// Brief    : Packet-level weighted round-robin grant for the shared UDP TX path.
//            Optional payload-stall watchdog: define UDP_TX_SCHED_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module udp_tx_wrr_scheduler #(
    parameter int S_COUNT        = 2,
    parameter int WEIGHT_WIDTH   = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    udp_tx_wrr_scheduler_if.master bus
);
    localparam int c_idx_w = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;

    localparam int       c_st_w       = 2;
    localparam bit [1:0] c_st_idle    = 2'd0;
    localparam bit [1:0] c_st_hdr     = 2'd1;
    localparam bit [1:0] c_st_payload = 2'd2;

    if (S_COUNT < 1 || S_COUNT > 16) begin : g_bad_s_count
        $error("udp_tx_wrr_scheduler: S_COUNT out of range");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("udp_tx_wrr_scheduler: TIMEOUT_CYCLES must be >= 2");
    end

    logic [c_st_w-1:0]       state_q, state_d;
    logic [c_idx_w-1:0]      ptr_q, ptr_d;
    logic [c_idx_w-1:0]      cur_q, cur_d;
    logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;
    logic                    hold_q, hold_d;
    logic [S_COUNT-1:0]      grant_q, grant_d;
    logic [c_idx_w-1:0]      grant_index_q, grant_index_d;
    logic                    busy_q, busy_d;

    logic                    found;
    logic [c_idx_w-1:0]      search_idx;
    logic [c_idx_w:0]        cand;
    logic [WEIGHT_WIDTH-1:0] wsel;
    logic [WEIGHT_WIDTH-1:0] credit_dec;
    logic [c_idx_w-1:0]      ptr_next;
    logic                    take_hold;
    logic                    hdr_fire;
    logic                    beat;
    logic                    pkt_done;
    logic                    wd_expire;

    assign hdr_fire  = bus.hdr_valid & bus.hdr_ready;
    assign beat      = bus.tvalid & bus.tready;
    assign pkt_done  = beat & bus.tlast;
    assign take_hold = hold_q & bus.req[cur_q];
    assign ptr_next  = (cur_q == c_idx_w'(S_COUNT - 1)) ? '0 : cur_q + 1'b1;
    assign wsel      = bus.weight[WEIGHT_WIDTH*search_idx +: WEIGHT_WIDTH];
    assign credit_dec = (credit_q != '0) ? credit_q - 1'b1 : '0;

    // Rotating priority search starting at ptr_q, wrapping past S_COUNT-1.
    always_comb begin
        found      = 1'b0;
        search_idx = '0;
        cand       = '0;
        for (int i = 0; i < S_COUNT; i++) begin
            cand = {1'b0, ptr_q} + (c_idx_w + 1)'(i);
            if (cand >= (c_idx_w + 1)'(S_COUNT)) begin
                cand = cand - (c_idx_w + 1)'(S_COUNT);
            end
            if (!found && bus.req[cand[c_idx_w-1:0]]) begin
                found      = 1'b1;
                search_idx = cand[c_idx_w-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= c_st_idle;
            ptr_q         <= '0;
            cur_q         <= '0;
            credit_q      <= '0;
            hold_q        <= 1'b0;
            grant_q       <= '0;
            grant_index_q <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            cur_q         <= cur_d;
            credit_q      <= credit_d;
            hold_q        <= hold_d;
            grant_q       <= grant_d;
            grant_index_q <= grant_index_d;
            busy_q        <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_idle:    if (take_hold || found) state_d = c_st_hdr;
            c_st_hdr:     if (hdr_fire) state_d = c_st_payload;
            c_st_payload: if (pkt_done || wd_expire) state_d = c_st_idle;
            default:      state_d = c_st_idle;
        endcase
    end

    always_comb begin
        ptr_d         = ptr_q;
        cur_d         = cur_q;
        credit_d      = credit_q;
        hold_d        = hold_q;
        grant_d       = grant_q;
        grant_index_d = grant_index_q;
        busy_d        = busy_q;
        case (state_q)
            c_st_idle: begin
                if (take_hold) begin
                    // Remaining credit carries over; weight is not re-sampled.
                    grant_d        = '0;
                    grant_d[cur_q] = 1'b1;
                    grant_index_d  = cur_q;
                    busy_d         = 1'b1;
                end else if (found) begin
                    cur_d               = search_idx;
                    credit_d            = (wsel == '0) ? WEIGHT_WIDTH'(1) : wsel;
                    grant_d             = '0;
                    grant_d[search_idx] = 1'b1;
                    grant_index_d       = search_idx;
                    busy_d              = 1'b1;
                end
            end
            c_st_payload: begin
                if (pkt_done) begin
                    grant_d  = '0;
                    busy_d   = 1'b0;
                    credit_d = credit_dec;
                    if (credit_dec != '0) begin
                        hold_d = 1'b1;
                    end else begin
                        hold_d = 1'b0;
                        ptr_d  = ptr_next;
                    end
                end else if (wd_expire) begin
                    grant_d  = '0;
                    busy_d   = 1'b0;
                    credit_d = '0;
                    hold_d   = 1'b0;
                    ptr_d    = ptr_next;
                end
            end
            default: ;
        endcase
    end

    assign bus.grant       = grant_q;
    assign bus.grant_index = grant_index_q;
    assign bus.busy        = busy_q;

`ifdef UDP_TX_SCHED_TIMEOUT_EN
    localparam int c_wd_w = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_wd_w-1:0] wd_q, wd_d;
    logic              timeout_q, timeout_d;

    assign wd_expire = (state_q == c_st_payload) && !beat &&
                       (wd_q == c_wd_w'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        wd_d      = wd_q;
        timeout_d = 1'b0;
        if (state_q == c_st_hdr && hdr_fire) begin
            wd_d = '0;
        end else if (state_q == c_st_payload) begin
            if (beat) begin
                wd_d = '0;
            end else if (wd_expire) begin
                wd_d      = '0;
                timeout_d = 1'b1;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign wd_expire   = 1'b0;
    assign bus.timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_udp_tx_wrr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_udp_tx_wrr_scheduler
// Brief    : Directed self-checking bench for udp_tx_wrr_scheduler (S_COUNT=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_udp_tx_wrr_scheduler;
    localparam int c_s_count = 2;
    localparam int c_ww      = 4;
    localparam int c_tmo     = 32;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    udp_tx_wrr_scheduler_if #(.S_COUNT(c_s_count), .WEIGHT_WIDTH(c_ww)) bus ();

    udp_tx_wrr_scheduler #(
        .S_COUNT       (c_s_count),
        .WEIGHT_WIDTH  (c_ww),
        .TIMEOUT_CYCLES(c_tmo)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; outputs are then stable for sampling and driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.req       = '0;
        bus.weight    = {4'd1, 4'd1};
        bus.hdr_valid = 1'b0;
        bus.hdr_ready = 1'b0;
        bus.tvalid    = 1'b0;
        bus.tready    = 1'b0;
        bus.tlast     = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic hdr();
        bus.hdr_valid = 1'b1;
        bus.hdr_ready = 1'b1;
        tick();
        bus.hdr_valid = 1'b0;
        bus.hdr_ready = 1'b0;
    endtask

    task automatic beat(input logic last);
        bus.tvalid = 1'b1;
        bus.tready = 1'b1;
        bus.tlast  = last;
        tick();
        bus.tvalid = 1'b0;
        bus.tready = 1'b0;
        bus.tlast  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.grant !== 2'b00) begin
            errors++; $display("FAIL reset_grant: got %b expected 00", bus.grant);
        end
        checks++;
        if (bus.grant_index !== 1'b0) begin
            errors++; $display("FAIL reset_grant_index: got %b expected 0", bus.grant_index);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.timeout !== 1'b0) begin
            errors++; $display("FAIL reset_busy_timeout: got busy=%b timeout=%b expected 0/0", bus.busy, bus.timeout);
        end
    endtask

    task automatic test_single();
        do_reset();
        bus.req = 2'b01;
        checks++;
        if (bus.grant !== 2'b00) begin
            errors++; $display("FAIL single_pre_grant: got %b expected 00", bus.grant);
        end
        tick();
        checks++;
        if (bus.grant !== 2'b01 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL single_grant: got grant=%b busy=%b expected 01/1", bus.grant, bus.busy);
        end
        bus.req = 2'b00;
        hdr();
        checks++;
        if (bus.grant !== 2'b01) begin
            errors++; $display("FAIL single_hold_after_req_drop: got %b expected 01", bus.grant);
        end
        for (int b = 0; b < 3; b++) beat(1'b0);
        checks++;
        if (bus.grant !== 2'b01 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL single_mid_packet: got grant=%b busy=%b expected 01/1", bus.grant, bus.busy);
        end
        beat(1'b1);
        checks++;
        if (bus.grant !== 2'b00 || bus.busy !== 1'b0 || bus.grant_index !== 1'b0) begin
            errors++; $display("FAIL single_release: got grant=%b busy=%b idx=%b expected 00/0/0", bus.grant, bus.busy, bus.grant_index);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g;
        do_reset();
        bus.req = 2'b11;
        tick();
        for (int p = 0; p < 6; p++) begin
            exp_g = (p % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if (bus.grant !== exp_g) begin
                errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", p, bus.grant, exp_g);
            end
            hdr();
            beat(1'b0);
            beat(1'b1);
            checks++;
            if (bus.busy !== 1'b0 || bus.grant_index !== exp_g[1]) begin
                errors++; $display("FAIL rr_idle_gap[%0d]: got busy=%b idx=%b expected 0/%b", p, bus.busy, bus.grant_index, exp_g[1]);
            end
            tick();
        end
    endtask

    task automatic test_weighted();
        logic [1:0] exp_w [8];
        logic [1:0] exp_z [4];
        exp_w = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10};
        exp_z = '{2'b01, 2'b10, 2'b01, 2'b10};
        do_reset();
        bus.weight = {4'd1, 4'd3};
        bus.req    = 2'b11;
        tick();
        for (int p = 0; p < 8; p++) begin
            checks++;
            if (bus.grant !== exp_w[p]) begin
                errors++; $display("FAIL wrr_grant[%0d]: got %b expected %b", p, bus.grant, exp_w[p]);
            end
            hdr();
            beat(1'b1);
            tick();
        end
        do_reset();
        bus.weight = {4'd1, 4'd0};
        bus.req    = 2'b11;
        tick();
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (bus.grant !== exp_z[p]) begin
                errors++; $display("FAIL wrr_zero_weight[%0d]: got %b expected %b", p, bus.grant, exp_z[p]);
            end
            hdr();
            beat(1'b1);
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic bad;
        do_reset();
        bus.req = 2'b01;
        tick();
        bus.req = 2'b00;
        hdr();
        beat(1'b0);
        bad = 1'b0;
        bus.tvalid = 1'b1;
        bus.tready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.grant !== 2'b01 || bus.timeout !== 1'b0) bad = 1'b1;
        end
        bus.tvalid = 1'b0;
        checks++;
        if (bad !== 1'b0) begin
            errors++; $display("FAIL bp_stall_hold: got grant=%b timeout=%b expected 01/0 throughout", bus.grant, bus.timeout);
        end
        beat(1'b0);
        beat(1'b1);
        checks++;
        if (bus.grant !== 2'b00 || bus.timeout !== 1'b0) begin
            errors++; $display("FAIL bp_release: got grant=%b timeout=%b expected 00/0", bus.grant, bus.timeout);
        end
    endtask

    task automatic test_watchdog();
        logic bad;
        do_reset();
        bus.req = 2'b11;
        tick();
        hdr();
        bad = 1'b0;
`ifdef UDP_TX_SCHED_TIMEOUT_EN
        for (int c = 1; c < c_tmo; c++) begin
            tick();
            if (bus.timeout !== 1'b0 || bus.grant !== 2'b01) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++; $display("FAIL wd_early: got timeout=%b grant=%b expected 0/01 before limit", bus.timeout, bus.grant);
        end
        tick();
        checks++;
        if (bus.timeout !== 1'b1 || bus.grant !== 2'b00 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL wd_fire: got timeout=%b grant=%b busy=%b expected 1/00/0", bus.timeout, bus.grant, bus.busy);
        end
        tick();
        checks++;
        if (bus.timeout !== 1'b0 || bus.grant !== 2'b10) begin
            errors++; $display("FAIL wd_regrant: got timeout=%b grant=%b expected 0/10", bus.timeout, bus.grant);
        end
`else
        for (int c = 0; c < c_tmo + 8; c++) begin
            tick();
            if (bus.timeout !== 1'b0 || bus.grant !== 2'b01) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++; $display("FAIL wd_disabled_hold: got timeout=%b grant=%b expected 0/01 throughout", bus.timeout, bus.grant);
        end
        beat(1'b1);
        checks++;
        if (bus.grant !== 2'b00) begin
            errors++; $display("FAIL wd_disabled_release: got %b expected 00", bus.grant);
        end
`endif
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        bus.req = 2'b01;
        tick();
        bus.req = 2'b00;
        hdr();
        beat(1'b0);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.grant !== 2'b00 || bus.busy !== 1'b0 || bus.grant_index !== 1'b0) begin
            errors++; $display("FAIL async_reset: got grant=%b busy=%b idx=%b expected 00/0/0", bus.grant, bus.busy, bus.grant_index);
        end
        tick();
        reset   = 1'b0;
        bus.req = 2'b10;
        tick();
        checks++;
        if (bus.grant !== 2'b10 || bus.grant_index !== 1'b1 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL post_reset_grant: got grant=%b idx=%b busy=%b expected 10/1/1", bus.grant, bus.grant_index, bus.busy);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_weighted();
        test_backpressure();
        test_watchdog();
        test_reset_mid_packet();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
